// File: rtl/tree_sprite_drawer.sv
// Tree sprite renderer: two-stage pixel pipeline over a packed 32x32 colour bitmap,
// with a frame-synchronous +/-1 pixel canopy sway driven by a four-state machine.
module tree_sprite_drawer #(
  parameter int          OBJECT_NUMBER_OF_Y_BITS = 5,
  parameter int          OBJECT_NUMBER_OF_X_BITS = 5,
  parameter logic [7:0]  TRANSPARENT_ENCODING    = 8'hFF,
  parameter int          CANOPY_ROWS             = 17,
  parameter int          SWAY_FRAMES             = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startOfFrame,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        InsideRectangle,
  input  logic        enable,
  input  logic [0:(1<<OBJECT_NUMBER_OF_Y_BITS)-1][0:(1<<OBJECT_NUMBER_OF_X_BITS)-1][7:0] object_colors,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic [1:0]  swayPhase
);

  localparam int H     = 1 << OBJECT_NUMBER_OF_Y_BITS;
  localparam int W     = 1 << OBJECT_NUMBER_OF_X_BITS;
  localparam int CNT_W = (SWAY_FRAMES > 1) ? $clog2(SWAY_FRAMES) : 1;

  localparam logic [CNT_W-1:0]                 CNT_LAST   = CNT_W'(SWAY_FRAMES - 1);
  localparam logic [10:0]                      W_LIM      = 11'(W);
  localparam logic [10:0]                      H_LIM      = 11'(H);
  localparam logic [OBJECT_NUMBER_OF_Y_BITS:0] CANOPY_LIM = (OBJECT_NUMBER_OF_Y_BITS+1)'(CANOPY_ROWS);
  localparam logic signed [11:0]               SRC_MAX    = 12'(W - 1);

  typedef enum logic [1:0] {
    CENTER_A = 2'd0,
    LEFT     = 2'd1,
    CENTER_B = 2'd2,
    RIGHT    = 2'd3
  } sway_state_t;

  sway_state_t state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;

  logic signed [11:0] shift_s;
  logic signed [11:0] src_x_s;
  logic               row_sway_s;
  logic               in_box_s;
  logic               src_ok_s;

  logic                               v1_r;
  logic [OBJECT_NUMBER_OF_Y_BITS-1:0] row1_r;
  logic [OBJECT_NUMBER_OF_X_BITS-1:0] col1_r;

  logic [7:0] color_s;
  logic       opaque_s;
  logic       draw_r;
  logic [7:0] rgb_r;

  // Sway state and frame counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CENTER_A;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Frame counting and sway state advance on the last frame of each state
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    if (startOfFrame) begin
      if (cnt_r == CNT_LAST) begin
        cnt_next_s = '0;
        case (state_r)
          CENTER_A: state_next_s = LEFT;
          LEFT:     state_next_s = CENTER_B;
          CENTER_B: state_next_s = RIGHT;
          RIGHT:    state_next_s = CENTER_A;
          default:  state_next_s = CENTER_A;
        endcase
      end else begin
        cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Canopy displacement for the current state, and the resulting source column
  always_comb begin
    case (state_r)
      LEFT:    shift_s = -12'sd1;
      RIGHT:   shift_s = 12'sd1;
      default: shift_s = 12'sd0;
    endcase
    row_sway_s = ({1'b0, offsetY[OBJECT_NUMBER_OF_Y_BITS-1:0]} < CANOPY_LIM);
    if (row_sway_s) begin
      src_x_s = $signed({1'b0, offsetX}) - shift_s;
    end else begin
      src_x_s = $signed({1'b0, offsetX});
    end
    in_box_s = InsideRectangle & enable & (offsetX < W_LIM) & (offsetY < H_LIM);
    src_ok_s = (src_x_s >= 12'sd0) && (src_x_s <= SRC_MAX);
  end

  // Stage 1: qualified scan position mapped to bitmap coordinates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r   <= 1'b0;
      row1_r <= '0;
      col1_r <= '0;
    end else begin
      v1_r   <= in_box_s & src_ok_s;
      row1_r <= offsetY[OBJECT_NUMBER_OF_Y_BITS-1:0];
      col1_r <= src_x_s[OBJECT_NUMBER_OF_X_BITS-1:0];
    end
  end

  // Bitmap lookup happens live against the current object_colors
  always_comb begin
    color_s  = object_colors[row1_r][col1_r];
    opaque_s = v1_r & (color_s != TRANSPARENT_ENCODING);
  end

  // Stage 2: registered drawing request and colour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      draw_r <= 1'b0;
      rgb_r  <= TRANSPARENT_ENCODING;
    end else begin
      draw_r <= opaque_s;
      rgb_r  <= opaque_s ? color_s : TRANSPARENT_ENCODING;
    end
  end

  assign drawingRequest = draw_r;
  assign RGBout         = rgb_r;
  assign swayPhase      = state_r;

endmodule

// File: doc/tree_sprite_drawer.md
# tree_sprite_drawer

Pipelined sprite renderer that sits directly downstream of the 32x32 tree colour bitmap. It consumes the bitmap's packed colour array together with the VGA scan position relative to the tree's top-left corner. It produces a registered drawing request and an 8-bit RGB pixel for the object mux. It also animates the tree's canopy with a frame-synchronous wind sway: a ±1-pixel horizontal shift cycled by a four-state machine. The trunk stays fixed.

## Interface
- OBJECT_NUMBER_OF_Y_BITS, 5, log2 of bitmap height (H = 32)
- OBJECT_NUMBER_OF_X_BITS, 5, log2 of bitmap width (W = 32)
- TRANSPARENT_ENCODING, 8'hFF, colour treated as "no pixel"
- CANOPY_ROWS, 17, rows 0..CANOPY_ROWS-1 sway; rows below are trunk
- SWAY_FRAMES, 30, frames spent in each sway state (≥1)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- startOfFrame  in  1  one-cycle pulse at start of each VGA frame
- offsetX  in  11  scan X minus tree left edge (unsigned)
- offsetY  in  11  scan Y minus tree top edge (unsigned)
- InsideRectangle  in  1  scan position lies inside the tree's 32x32 box
- enable  in  1  1 = tree visible; 0 = suppress drawing
- object_colors  in  [0:H-1][0:W-1][7:0]  packed bitmap colours, row-major
- drawingRequest  out  1  registered: current pixel is opaque tree pixel
- RGBout  out  8  registered pixel colour
- swayPhase  out  2  current sway state encoding

## Operation
- Sway FSM states, with encoding and canopy displacement s:
  - CENTER_A: 0, s = 0
  - LEFT: 1, s = -1
  - CENTER_B: 2, s = 0
  - RIGHT: 3, s = +1
  - Order is CENTER_A→LEFT→CENTER_B→RIGHT→CENTER_A.
- Frame counter (width ≥ clog2(SWAY_FRAMES)) increments on each startOfFrame pulse.
- On a pulse with counter == SWAY_FRAMES-1: counter→0 and FSM advances one state. With SWAY_FRAMES = 1 the FSM advances on every pulse.
- swayPhase = state encoding. The state changes only on startOfFrame, so s is constant within a frame.
- Stage 1 (registered):
  - v1 = InsideRectangle & enable & (offsetX < 32) & (offsetY < 32).
  - row1 = offsetY[4:0].
  - Source column: srcX = offsetX − s if row < CANOPY_ROWS, else offsetX. Computed 12-bit signed.
  - If srcX < 0 or srcX > 31, v1 = 0.
  - col1 = srcX[4:0].
- Stage 2 (registered):
  - c = object_colors[row1][col1].
  - drawingRequest = v1 & (c != TRANSPARENT_ENCODING).
  - RGBout = c when drawingRequest would be 1; otherwise TRANSPARENT_ENCODING.
- enable = 0 blocks drawing only; the sway counter and FSM keep running.
- object_colors is sampled at stage 2 with no internal storage. Changes to it appear on the next stage-2 update.

## Timing
- Latency: inputs sampled at edge N appear on drawingRequest/RGBout after edge N+1 (2-cycle pipeline). Throughput is one pixel per clock, no stalls.
- swayPhase updates on the clk edge that samples the qualifying startOfFrame pulse. The new s applies to pixels sampled from the following cycle.
- Reset values, applied immediately on rst assertion regardless of clk:
  - drawingRequest = 0
  - RGBout = TRANSPARENT_ENCODING
  - swayPhase = 0 (CENTER_A)
  - frame counter = 0
  - v1 = 0
- Reset asserted mid-frame or mid-sway discards in-flight pixels. The first valid output comes 2 edges after rst deasserts.
- startOfFrame coincident with InsideRectangle: that pixel uses the pre-update s.
- Row boundary: row CANOPY_ROWS-1 shifts; row CANOPY_ROWS is never shifted.
- Column boundary:
  - s = +1, offsetX = 0 → srcX = −1, transparent.
  - s = −1, offsetX = 31 → srcX = 32, transparent.
  - Source columns shifted in from outside the bitmap always read as transparent.

## Test plan
Bench bitmap pattern: P(r,c) = {r[2:0], c[4:0]}. The only transparent pixels are those with r[2:0] = 7 and c = 31.

- **Basic draw and latency.** After reset, hold InsideRectangle = 1, enable = 1, offsetX = 5, offsetY = 2 from cycle 0. Expect drawingRequest = 1 and RGBout = 8'h45 after the second edge, and drawingRequest = 0 before it.
- **Transparency.** offsetY = 7, offsetX = 31, CENTER_A → drawingRequest = 0, RGBout = 8'hFF. Changing to offsetX = 30 → RGBout = 8'hFE, drawingRequest = 1.
- **Sway progression (SWAY_FRAMES = 2).** Issue 8 startOfFrame pulses. Expect swayPhase 0,1,1,2,2,3,3,0 after pulses 1..8.
- **Canopy shift in LEFT.** offsetY = 3, offsetX = 4 → RGBout = 8'h65 (col 5). offsetX = 31 → transparent. Trunk row offsetY = 20, offsetX = 4 → RGBout = 8'h84 (unshifted).
- **Qualification.** InsideRectangle = 0, or enable = 0, or offsetX = 40 → drawingRequest = 0 and RGBout = 8'hFF. With enable = 0, swayPhase still advances on startOfFrame.
- **Async reset mid-operation.** In state RIGHT with drawingRequest = 1, assert rst between clock edges. All outputs must reach reset values without a clock edge, swayPhase = 0, and the first new output appears 2 edges after release.
